multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control unit of the multi-cycle RV32I core: Moore FSM plus ALU and immediate decoders.
- Drives every select and enable of the datapath stage from the latched instruction fields and the ALU zero flag.
- Generates MemWrite toward external memory.
- Sits directly upstream of the datapath; one instance per core.

Parameters:
- none (fixed RV32I subset: lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous active-low reset (0 = reset, sampled on rising clk)
- op  input  7  Instr[6:0]
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- Zero  input  1  ALU zero flag from datapath
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  output  2  00 WriteData, 01 ImmExt, 10 constant 4
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  output  1  0 PC, 1 Result
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IRWrite, PCWrite, RegWrite, MemWrite  output  1 each  write enables
- illegal  output  1  sticky: unsupported instruction decoded

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL. Outputs are Moore functions of state, except:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ALUControl also depends on op/funct3/funct7b5.
  - ImmSrc depends on op only.
- Reset:
  - While reset==0: next state FETCH; IRWrite, PCWrite, RegWrite and MemWrite forced 0; illegal=0.
  - First cycle after release is FETCH.
  - Reset asserted in any state, including mid-instruction or ILLEGAL, aborts it with no further writes.
- Per-state outputs (unlisted selects = 00, unlisted enables = 0; ALUOp 00 add, 01 sub, 10 funct-decoded):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op, or funct3 not in {000, 010, 110, 111} for R/I, or funct3!=000 for branch -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - ILLEGAL: all enables 0, illegal=1; self-loop until reset.
- Latency in cycles, FETCH inclusive: lw 5; sw 4; R 4; I 4; beq 3; jal 4.
- ALU decoder, ALUOp=10, by funct3:
  - 000: sub if {op[5], funct7b5}==11, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
- ImmSrc: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.
- op, funct3 and funct7b5 are read only in DECODE and later; values seen during FETCH are ignored (IR not yet loaded).

Optional Feature:
- Macro: CTRL_BNE_EN
- Defined: funct3=001 with op 1100011 is legal (bne). In BEQ state, PCWrite = Branch & ~Zero for bne, Branch & Zero for beq; latency 3.
- Undefined: funct3=001 branch goes to ILLEGAL.

Test Plan:
- Hold reset=0 for 3 cycles with op=0110011 -> IRWrite=PCWrite=RegWrite=MemWrite=0 throughout; first cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- lw (op 0000011, funct3 010) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; AdrSrc=1 in cycle 4.
- sub (op 0110011, funct3 000, funct7b5=1) -> ALUControl=001 in EXECUTER; addi with funct7b5=1 (op 0010011) -> ALUControl=000; RegWrite=1 in cycle 4.
- beq with Zero=1 in cycle 3 -> PCWrite=1, ALUControl=001; same with Zero=0 -> PCWrite=0; next cycle FETCH in both cases.
- jal (op 1101111) -> ImmSrc=11; cycle 3 PCWrite=1, ALUSrcA=01, ALUSrcB=10; cycle 4 RegWrite=1, ResultSrc=00.
- op 1110011 -> ILLEGAL after DECODE; illegal=1 and all enables 0 for 10 cycles; reset=0 for 1 cycle -> illegal=0, FETCH resumes.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore FSM with ALU and immediate decoders.
// Optional CTRL_BNE_EN macro adds bne support through the BEQ state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  } state_t;

  state_t state, next;

  logic [1:0] aluop;
  logic       branch, pcupdate, irw, rw, mw, ill;
  logic       funct_ok, br_ok, taken;

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);

`ifdef CTRL_BNE_EN
  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign taken = funct3[0] ? ~Zero : Zero;
`else
  assign br_ok = (funct3 == 3'b000);
  assign taken = Zero;
`endif

  always_comb begin
    next      = state;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    aluop     = 2'b00;
    branch    = 1'b0;
    pcupdate  = 1'b0;
    irw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    ill       = 1'b0;
    unique case (state)
      FETCH: begin
        irw = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; pcupdate = 1'b1;
        next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = funct_ok ? EXECUTER : ILLEGAL;
          OP_I:         next = funct_ok ? EXECUTEI : ILLEGAL;
          OP_BR:        next = br_ok ? BEQ : ILLEGAL;
          OP_JAL:       next = JAL;
          default:      next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01;
        next = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD:  begin AdrSrc = 1'b1; next = MEMWB; end
      MEMWB:    begin ResultSrc = 2'b01; rw = 1'b1; next = FETCH; end
      MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; next = FETCH; end
      EXECUTER: begin ALUSrcA = 2'b10; aluop = 2'b10; next = ALUWB; end
      EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; aluop = 2'b10; next = ALUWB; end
      ALUWB:    begin rw = 1'b1; next = FETCH; end
      BEQ:      begin ALUSrcA = 2'b10; aluop = 2'b01; branch = 1'b1; next = FETCH; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pcupdate = 1'b1; next = ALUWB; end
      ILLEGAL:  begin ill = 1'b1; next = ILLEGAL; end
      default:  next = FETCH;
    endcase
  end

  // Reset low must suppress every write in the same cycle, not just the next one.
  assign IRWrite  = reset & irw;
  assign RegWrite = reset & rw;
  assign MemWrite = reset & mw;
  assign PCWrite  = reset & (pcupdate | (branch & taken));
  assign illegal  = reset & ill;

  always_comb begin
    ALUControl = 3'b000;
    unique case (aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [3:0] en = {IRWrite, PCWrite, RegWrite, MemWrite};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle past the opposite edge
  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  // reset for two edges, release; the caller then sits in FETCH
  task automatic rst;
    reset = 1'b0;
    cyc;
    cyc;
    reset = 1'b1;
    #1;
  endtask

  // check FETCH, step into DECODE
  task automatic fetch(input string tag);
    chk({tag, " fetch en"}, en, 4'b1100);
    cyc;
    chk({tag, " decode en"}, en, 4'b0000);
    chk({tag, " decode srcA"}, ALUSrcA, 2'b01);
  endtask

  initial begin
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      chk("reset en", en, 4'b0000);
      chk("reset illegal", illegal, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk("first IRWrite", IRWrite, 1'b1);
    chk("first PCWrite", PCWrite, 1'b1);
    chk("first ALUSrcB", ALUSrcB, 2'b10);
    chk("first ResultSrc", ResultSrc, 2'b10);

    // lw
    op = 7'b0000011; funct3 = 3'b010; rst;
    fetch("lw");
    chk("lw ImmSrc", ImmSrc, 2'b00);
    cyc; chk("lw memadr srcA", ALUSrcA, 2'b10); chk("lw memadr srcB", ALUSrcB, 2'b01);
    chk("lw memadr alu", ALUControl, 3'b000); chk("lw memadr en", en, 4'b0000);
    cyc; chk("lw memread adr", AdrSrc, 1'b1); chk("lw memread en", en, 4'b0000);
    cyc; chk("lw memwb en", en, 4'b0010); chk("lw memwb res", ResultSrc, 2'b01);
    cyc; chk("lw next fetch", en, 4'b1100);

    // sw
    op = 7'b0100011; funct3 = 3'b010; rst;
    fetch("sw");
    chk("sw ImmSrc", ImmSrc, 2'b01);
    cyc; chk("sw memadr en", en, 4'b0000);
    cyc; chk("sw memwrite en", en, 4'b0001); chk("sw memwrite adr", AdrSrc, 1'b1);
    cyc; chk("sw next fetch", en, 4'b1100);

    // sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; rst;
    fetch("sub");
    cyc; chk("sub alu", ALUControl, 3'b001); chk("sub srcA", ALUSrcA, 2'b10);
    chk("sub srcB", ALUSrcB, 2'b00);
    cyc; chk("sub wb en", en, 4'b0010); chk("sub wb res", ResultSrc, 2'b00);
    cyc; chk("sub next fetch", en, 4'b1100);

    // addi with funct7b5 set must still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; rst;
    fetch("addi");
    cyc; chk("addi alu", ALUControl, 3'b000); chk("addi srcB", ALUSrcB, 2'b01);
    cyc; chk("addi wb en", en, 4'b0010);

    // remaining funct-decoded ops
    op = 7'b0010011; funct3 = 3'b010; funct7b5 = 1'b0; rst;
    fetch("slti"); cyc; chk("slti alu", ALUControl, 3'b101);
    op = 7'b0110011; funct3 = 3'b110; rst;
    fetch("or"); cyc; chk("or alu", ALUControl, 3'b011);
    op = 7'b0010011; funct3 = 3'b111; rst;
    fetch("andi"); cyc; chk("andi alu", ALUControl, 3'b010);
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; rst;
    fetch("add"); cyc; chk("add alu", ALUControl, 3'b000);

    // beq taken / not taken
    op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; rst;
    fetch("beq1");
    chk("beq ImmSrc", ImmSrc, 2'b10);
    cyc; chk("beq1 PCWrite", PCWrite, 1'b1); chk("beq1 alu", ALUControl, 3'b001);
    chk("beq1 other en", {IRWrite, RegWrite, MemWrite}, 3'b000);
    cyc; chk("beq1 next fetch", en, 4'b1100);
    Zero = 1'b0; rst;
    fetch("beq0");
    cyc; chk("beq0 PCWrite", PCWrite, 1'b0);
    cyc; chk("beq0 next fetch", en, 4'b1100);

    // jal
    op = 7'b1101111; funct3 = 3'b000; rst;
    fetch("jal");
    chk("jal ImmSrc", ImmSrc, 2'b11);
    cyc; chk("jal PCWrite", PCWrite, 1'b1); chk("jal srcA", ALUSrcA, 2'b01);
    chk("jal srcB", ALUSrcB, 2'b10); chk("jal en", en, 4'b0100);
    cyc; chk("jal wb en", en, 4'b0010); chk("jal wb res", ResultSrc, 2'b00);
    cyc; chk("jal next fetch", en, 4'b1100);

    // bne: legal only with the optional feature
    op = 7'b1100011; funct3 = 3'b001; Zero = 1'b0; rst;
    fetch("bne");
    cyc;
`ifdef CTRL_BNE_EN
    chk("bne PCWrite", PCWrite, 1'b1); chk("bne illegal", illegal, 1'b0);
    Zero = 1'b1; #1; chk("bne nt PCWrite", PCWrite, 1'b0);
`else
    chk("bne illegal", illegal, 1'b1); chk("bne en", en, 4'b0000);
`endif

    // unsupported funct3 on R-type
    op = 7'b0110011; funct3 = 3'b001; rst;
    fetch("r f3"); cyc; chk("r f3 illegal", illegal, 1'b1);

    // reset mid-instruction aborts before the write
    op = 7'b0000011; funct3 = 3'b010; rst;
    fetch("abort"); cyc; cyc;
    reset = 1'b0; #1; chk("abort en", en, 4'b0000);
    cyc; chk("abort held en", en, 4'b0000);
    reset = 1'b1; #1; chk("abort fetch", en, 4'b1100);

    // ecall-style op: illegal and sticky
    op = 7'b1110011; funct3 = 3'b000; rst;
    fetch("ill");
    for (int i = 0; i < 10; i++) begin
      cyc;
      chk("ill flag", illegal, 1'b1);
      chk("ill en", en, 4'b0000);
    end
    reset = 1'b0; #1;
    chk("ill reset flag", illegal, 1'b0); chk("ill reset en", en, 4'b0000);
    cyc;
    reset = 1'b1; #1;
    chk("ill resume fetch", en, 4'b1100); chk("ill resume flag", illegal, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
